// File: rtl/clock_display_scan.sv
// clock_display_scan: snapshots clock digits on timer irq and scans them onto a muxed 7-segment display
module clock_display_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit AN_ACTIVE_LOW  = 1,
  parameter bit LZ_SUPPRESS    = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] reg_h1_in,
  input  logic [7:0] reg_h2_in,
  input  logic [7:0] reg_m1_in,
  input  logic [7:0] reg_m2_in,
  input  logic [7:0] reg_s1_in,
  input  logic [7:0] reg_s2_in,
  input  logic       timer_irq_irq,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       snap_valid,
  output logic       digit_err
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [9:0][6:0] BCD = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [5:0] AN_OFF = {6{AN_ACTIVE_LOW}};
  logic            irq_d;
  logic            colon_phase;
  logic            capture;
  logic [5:0][7:0] snap;
  logic [2:0]      slot;
  logic [CW-1:0]   cnt;
  logic [7:0]      cur;
  logic [6:0]      seg_raw;
  logic [5:0]      an_raw;
  logic            dp_raw;
  logic            err_n;
  function automatic logic ok(input logic [7:0] b);
    return b[7:4] == 4'd0 && b[3:0] <= 4'd9;
  endfunction
  // Edge detect, current digit selection and next output values
  always_comb begin
    capture = timer_irq_irq & ~irq_d;
    cur = snap[slot];
    err_n = ~&{ok(snap[0]), ok(snap[1]), ok(snap[2]), ok(snap[3]), ok(snap[4]), ok(snap[5])};
    seg_raw = (LZ_SUPPRESS && slot == 3'd0 && cur == 8'd0) ? 7'h00 : ok(cur) ? BCD[cur[3:0]] : 7'h40;
    dp_raw = colon_phase && (slot == 3'd1 || slot == 3'd3);
    an_raw = (snap_valid && int'(cnt) >= BLANK_CYCLES) ? 6'b100000 >> slot : 6'b000000;
  end
  // Snapshot capture, colon phase and scan position; captures never disturb the scan
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_d <= 1'b0;
      snap <= '0;
      colon_phase <= 1'b0;
      snap_valid <= 1'b0;
      cnt <= '0;
      slot <= 3'd0;
    end else begin
      irq_d <= timer_irq_irq;
      if (capture) begin
        snap <= {reg_s2_in, reg_s1_in, reg_m2_in, reg_m1_in, reg_h2_in, reg_h1_in};
        colon_phase <= ~colon_phase;
        snap_valid <= 1'b1;
      end
      cnt <= (cnt == CW'(SCAN_DIV - 1)) ? '0 : cnt + 1'b1;
      if (cnt == CW'(SCAN_DIV - 1)) slot <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
    end
  end
  // Registered display pins at the configured polarity
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      seg <= SEG_OFF;
      dp <= SEG_ACTIVE_LOW;
      an <= AN_OFF;
      digit_err <= 1'b0;
    end else begin
      seg <= seg_raw ^ SEG_OFF;
      dp <= dp_raw ^ SEG_ACTIVE_LOW;
      an <= an_raw ^ AN_OFF;
      digit_err <= err_n;
    end
  end
endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan: directed self-checking bench for clock_display_scan
module tb_clock_display_scan;
  logic clk, rst_n, irq;
  logic [7:0] h1, h2, m1, m2, s1, s2;
  logic [6:0] seg;
  logic dp, snap_valid, digit_err;
  logic [5:0] an;
  int checks, errors, n;
  logic [7:0] exp_snap [6];
  logic exp_phase, exp_valid;
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  clock_display_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .LZ_SUPPRESS(1)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .reg_h1_in(h1), .reg_h2_in(h2), .reg_m1_in(m1), .reg_m2_in(m2), .reg_s1_in(s1), .reg_s2_in(s2),
    .timer_irq_irq(irq), .seg(seg), .dp(dp), .an(an), .snap_valid(snap_valid), .digit_err(digit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edges since reset release; outputs after edge k show scan position k-1
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else n <= n + 1;

  function automatic logic [6:0] e_seg(input int k);
    int s;
    logic [7:0] b;
    s = ((k - 1) / 8) % 6;
    b = exp_snap[s];
    if (s == 0 && b == 8'h00) return 7'h7F;
    if (b[7:4] != 4'h0 || b[3:0] > 4'd9) return ~7'h40;
    return ~pat[b[3:0]];
  endfunction

  function automatic logic [5:0] e_an(input int k);
    int c, s;
    logic [5:0] one;
    c = (k - 1) % 8;
    s = ((k - 1) / 8) % 6;
    one = 6'b100000 >> s;
    return (exp_valid && c >= 2) ? ~one : 6'b111111;
  endfunction

  function automatic logic e_dp(input int k);
    int s;
    s = ((k - 1) / 8) % 6;
    return !(exp_phase && (s == 1 || s == 3));
  endfunction

  task automatic set_in(input logic [7:0] a, b, c, d, e, f);
    h1 = a; h2 = b; m1 = c; m2 = d; s1 = e; s2 = f;
  endtask

  // one-cycle irq pulse; returns at the negedge right after the capture edge
  task automatic pulse(input logic [7:0] a, b, c, d, e, f);
    @(negedge clk);
    set_in(a, b, c, d, e, f);
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    exp_snap = '{a, b, c, d, e, f};
    exp_phase = ~exp_phase;
    exp_valid = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    irq = 1'b0;
    set_in(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    exp_snap = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_phase = 1'b0;
    exp_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (an !== 6'b111111) begin errors++; $display("FAIL reset_an got=%b want=111111", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h want=7f", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b want=1", dp); end
    checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", snap_valid); end
    checks++; if (digit_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", digit_err); end
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (an !== 6'b111111 || snap_valid !== 1'b0) begin
        errors++; $display("FAIL dark_no_irq n=%0d an=%b valid=%b want an=111111 valid=0", n, an, snap_valid);
      end
    end
  endtask

  task automatic test_capture;
    pulse(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    checks++; if (snap_valid !== 1'b1) begin errors++; $display("FAIL capture_valid got=%b want=1", snap_valid); end
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg(n) || an !== e_an(n) || dp !== e_dp(n) || digit_err !== 1'b0) begin
        errors++; $display("FAIL scan_capture n=%0d seg=%h/%h an=%b/%b dp=%b/%b err=%b/0", n, seg, e_seg(n), an, e_an(n), dp, e_dp(n), digit_err);
      end
    end
  endtask

  task automatic test_hold;
    @(negedge clk);
    irq = 1'b1;
    @(negedge clk);
    set_in(8'h02, 8'h03, 8'h05, 8'h09, 8'h05, 8'h09);
    exp_phase = ~exp_phase;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg(n) || an !== e_an(n) || dp !== e_dp(n)) begin
        errors++; $display("FAIL scan_hold_high n=%0d seg=%h/%h an=%b/%b dp=%b/%b", n, seg, e_seg(n), an, e_an(n), dp, e_dp(n));
      end
    end
    irq = 1'b0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg(n) || an !== e_an(n) || dp !== e_dp(n)) begin
        errors++; $display("FAIL scan_hold_after n=%0d seg=%h/%h an=%b/%b dp=%b/%b", n, seg, e_seg(n), an, e_an(n), dp, e_dp(n));
      end
    end
    pulse(8'h02, 8'h03, 8'h05, 8'h09, 8'h05, 8'h09);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg(n) || an !== e_an(n) || dp !== e_dp(n)) begin
        errors++; $display("FAIL scan_new_pulse n=%0d seg=%h/%h an=%b/%b dp=%b/%b", n, seg, e_seg(n), an, e_an(n), dp, e_dp(n));
      end
    end
  endtask

  task automatic test_digit_err;
    pulse(8'h00, 8'h03, 8'h04, 8'h1A, 8'h05, 8'h06);
    checks++; if (digit_err !== 1'b0) begin errors++; $display("FAIL err_not_early got=%b want=0", digit_err); end
    @(negedge clk);
    checks++; if (digit_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b want=1", digit_err); end
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg(n) || an !== e_an(n) || dp !== e_dp(n) || digit_err !== 1'b1) begin
        errors++; $display("FAIL scan_invalid n=%0d seg=%h/%h an=%b/%b dp=%b/%b err=%b/1", n, seg, e_seg(n), an, e_an(n), dp, e_dp(n), digit_err);
      end
    end
    pulse(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    checks++; if (digit_err !== 1'b1) begin errors++; $display("FAIL err_hold got=%b want=1", digit_err); end
    @(negedge clk);
    checks++; if (digit_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", digit_err); end
  endtask

  task automatic test_wrap_capture;
    do @(negedge clk); while (n % 48 != 46);
    pulse(8'h02, 8'h03, 8'h05, 8'h09, 8'h05, 8'h09);
    @(negedge clk);
    checks++; if (seg !== ~7'h5B) begin errors++; $display("FAIL wrap_h1_seg got=%h want=%h", seg, ~7'h5B); end
    checks++; if (an !== 6'b111111) begin errors++; $display("FAIL wrap_h1_blank got=%b want=111111", an); end
    for (int i = 0; i < 47; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg(n) || an !== e_an(n) || dp !== e_dp(n)) begin
        errors++; $display("FAIL scan_wrap n=%0d seg=%h/%h an=%b/%b dp=%b/%b", n, seg, e_seg(n), an, e_an(n), dp, e_dp(n));
      end
    end
  endtask

  task automatic test_reset_mid;
    do @(negedge clk); while (n % 8 != 4);
    rst_n = 1'b0;
    #1;
    checks++; if (an !== 6'b111111) begin errors++; $display("FAIL async_an got=%b want=111111", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL async_seg got=%h want=7f", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL async_dp got=%b want=1", dp); end
    checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%b want=0", snap_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_snap = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_phase = 1'b0;
    exp_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (an !== 6'b111111 || snap_valid !== 1'b0) begin
        errors++; $display("FAIL dark_after_reset n=%0d an=%b valid=%b want an=111111 valid=0", n, an, snap_valid);
      end
    end
    pulse(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg(n) || an !== e_an(n) || dp !== e_dp(n)) begin
        errors++; $display("FAIL scan_after_reset n=%0d seg=%h/%h an=%b/%b dp=%b/%b", n, seg, e_seg(n), an, e_an(n), dp, e_dp(n));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_capture;
    test_hold;
    test_digit_err;
    test_wrap_capture;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
